// File: rtl/generateproof_hls_deadlock_report_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : generateproof_hls_deadlock_report_ctrl
// Purpose  : Central deadlock-report controller for the GenerateProof dataflow
//            region. Debounces a candidate deadlock from the per-process detect
//            units, launches the report token from one originating process,
//            records the processes the token visits and latches a sticky
//            report for host/debug readout.
// Ports    :
//   clock            - rising-edge clock
//   reset            - asynchronous, active-low reset
//   dl_detect_vec    - per-process dl_detect_out
//   token_return_vec - per-process OR of token_in_vec
//   report_ack       - single-cycle pulse that clears the report
//   origin_vec       - one-hot origin strobe to the detect units (Moore)
//   token_clear      - broadcast token clear (Mealy on token_return_vec)
//   dl_detect_all    - broadcast dl_detect_in while a report is in progress
//   deadlock_valid   - sticky report-valid flag
//   deadlock_proc    - index of the originating process
//   deadlock_path    - bitmap of processes the token visited
//   deadlock_ts      - timestamp taken in the last confirmation cycle
//   trace_timeout    - trace ended by timeout rather than token return
// Revision : 1.0 - initial release
// ============================================================================
module generateproof_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID_W      = 2,
  parameter int CONFIRM_CYCLES = 4,
  parameter int TRACE_TIMEOUT  = 64,
  parameter int TS_W           = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PROC_NUM-1:0]  dl_detect_vec,
  input  logic [PROC_NUM-1:0]  token_return_vec,
  input  logic                 report_ack,
  output logic [PROC_NUM-1:0]  origin_vec,
  output logic                 token_clear,
  output logic                 dl_detect_all,
  output logic                 deadlock_valid,
  output logic [PROC_ID_W-1:0] deadlock_proc,
  output logic [PROC_NUM-1:0]  deadlock_path,
  output logic [TS_W-1:0]      deadlock_ts,
  output logic                 trace_timeout
);

  localparam int TMR_W = $clog2(TRACE_TIMEOUT);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CONFIRM = 3'd1;
  localparam logic [2:0] ST_ORIGIN  = 3'd2;
  localparam logic [2:0] ST_TRACE   = 3'd3;
  localparam logic [2:0] ST_REPORT  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [TS_W-1:0]      ts_q;
  logic [PROC_ID_W-1:0] cand_q, cand_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [PROC_NUM-1:0]  path_q, path_d;
  logic [PROC_ID_W-1:0] proc_q, proc_d;
  logic [TS_W-1:0]      dts_q, dts_d;
  logic                 to_q, to_d;

  logic [PROC_ID_W-1:0] w_low_idx;
  logic [PROC_NUM-1:0]  w_cand_onehot;
  logic [7:0]           w_cnt_inc;
  logic                 w_token_clear;

  // Lowest set detect bit wins: scanning downwards leaves the lowest index.
  always_comb begin
    w_low_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (dl_detect_vec[i]) begin
        w_low_idx = i[PROC_ID_W-1:0];
      end
    end
  end

  assign w_cand_onehot = {{(PROC_NUM-1){1'b0}}, 1'b1} << cand_q;
  assign w_cnt_inc     = cnt_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    path_d        = path_q;
    proc_d        = proc_q;
    dts_d         = dts_q;
    to_d          = to_q;
    w_token_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|dl_detect_vec) begin
          cand_d  = w_low_idx;
          cnt_d   = 8'd1;
          state_d = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        // Only the chosen candidate is watched; it must hold without a gap.
        if (!dl_detect_vec[cand_q]) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == 8'(CONFIRM_CYCLES)) begin
            dts_d   = ts_q;
            state_d = ST_ORIGIN;
          end
        end
      end
      ST_ORIGIN: begin
        path_d  = w_cand_onehot;
        proc_d  = cand_q;
        tmr_d   = '0;
        state_d = ST_TRACE;
      end
      ST_TRACE: begin
        path_d = path_q | token_return_vec;
        tmr_d  = tmr_q + TMR_W'(1);
        // Token back at the origin beats a timeout in the same cycle.
        if (token_return_vec[cand_q]) begin
          w_token_clear = 1'b1;
          to_d          = 1'b0;
          state_d       = ST_REPORT;
        end else if (tmr_q == TMR_W'(TRACE_TIMEOUT - 1)) begin
          w_token_clear = 1'b1;
          to_d          = 1'b1;
          state_d       = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (report_ack) begin
          path_d  = '0;
          proc_d  = '0;
          dts_d   = '0;
          to_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ts_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      path_q  <= '0;
      proc_q  <= '0;
      dts_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + TS_W'(1);
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      path_q  <= path_d;
      proc_q  <= proc_d;
      dts_q   <= dts_d;
      to_q    <= to_d;
    end
  end

  assign origin_vec     = (state_q == ST_ORIGIN) ? w_cand_onehot : '0;
  assign dl_detect_all  = (state_q == ST_ORIGIN) || (state_q == ST_TRACE) ||
                          (state_q == ST_REPORT);
  assign token_clear    = w_token_clear;
  assign deadlock_valid = (state_q == ST_REPORT);
  assign deadlock_proc  = proc_q;
  assign deadlock_path  = path_q;
  assign deadlock_ts    = dts_q;
  assign trace_timeout  = to_q;

endmodule
`default_nettype wire
